crc8_frame_ctrl: RTL



---
 rtl/crc8_pkg.sv | 16 +
 rtl/crc8_bit_engine.sv | 26 ++
 rtl/crc8_frame_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/crc8_pkg.sv
// Shared definitions for the CRC-8 frame controller: FSM states, CRC
// polynomial/initial value and the bit-counter width.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  localparam int         BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    OUT_DATA = 2'd2,
    OUT_CRC  = 2'd3
  } state_t;

endpackage

// File: rtl/crc8_bit_engine.sv
// Serial CRC-8 engine: absorbs one message bit (MSB-first) per enabled cycle.
// clr returns the register to the initial value and overrides en.
module crc8_bit_engine
  import crc8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic feedback;

  assign feedback = crc[7] ^ din;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/crc8_frame_ctrl.sv
// Byte-stream CRC-8 framer: echoes each input byte, then appends the CRC.
// Define CRC8_FRAME_CHECK_EN to add a receive-check mode (chk_mode/chk_valid/chk_ok).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for the next input byte
// SHIFT    | 8 cycles feeding the held byte MSB-first into the CRC engine
// OUT_DATA | presenting the held byte downstream
// OUT_CRC  | presenting the final CRC with m_last (generate mode only)
module crc8_frame_ctrl
  import crc8_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             busy,
  output logic [LEN_W-1:0] frame_len
`ifdef CRC8_FRAME_CHECK_EN
  ,
  input  logic             chk_mode,
  output logic             chk_valid,
  output logic             chk_ok
`endif
);

  state_t                 state_q, state_d;
  logic [7:0]             byte_q;
  logic                   last_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [LEN_W-1:0]       len_q;
  logic [7:0]             crc;
  logic                   crc_en;
  logic                   frame_clr;
  logic                   accept;
  logic                   chk_frame;

`ifdef CRC8_FRAME_CHECK_EN
  logic chk_mode_q;

  assign chk_frame = chk_mode_q;

  // Mode is latched on the first byte of a frame and held until the frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_mode_q <= 1'b0;
    end else if (accept && (len_q == '0)) begin
      chk_mode_q <= chk_mode;
    end
  end

  assign chk_valid = chk_frame && (state_q == OUT_DATA) && last_q && m_ready && !abort && !rst;
  assign chk_ok    = chk_valid && (crc == 8'h00);
`else
  assign chk_frame = 1'b0;
`endif

  assign accept = s_valid && s_ready;

  crc8_bit_engine u_engine (
    .clk (clk),
    .rst (rst),
    .clr (frame_clr),
    .en  (crc_en),
    .din (byte_q[~bit_cnt_q]),
    .crc (crc)
  );

  always_comb begin
    state_d   = state_q;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_data    = 8'h00;
    m_last    = 1'b0;
    crc_en    = 1'b0;
    frame_clr = 1'b0;

    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_d = SHIFT;
      end
      SHIFT: begin
        crc_en = 1'b1;
        if (bit_cnt_q == BIT_CNT_W'(7)) state_d = OUT_DATA;
      end
      OUT_DATA: begin
        m_valid = 1'b1;
        m_data  = byte_q;
        m_last  = chk_frame && last_q;
        if (m_ready) begin
          if (last_q && !chk_frame) begin
            state_d = OUT_CRC;
          end else begin
            state_d   = IDLE;
            frame_clr = last_q;
          end
        end
      end
      OUT_CRC: begin
        m_valid = 1'b1;
        m_data  = crc;
        m_last  = 1'b1;
        if (m_ready) begin
          state_d   = IDLE;
          frame_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort beats any handshake this cycle; outputs already presented stay
    // valid for this cycle and drop on the next.
    if (abort) begin
      state_d   = IDLE;
      s_ready   = 1'b0;
      crc_en    = 1'b0;
      frame_clr = 1'b1;
    end

    if (rst) begin
      s_ready = 1'b0;
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_last  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      byte_q    <= 8'h00;
      last_q    <= 1'b0;
      bit_cnt_q <= '0;
      len_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        byte_q    <= s_data;
        last_q    <= s_last;
        bit_cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (frame_clr) begin
        len_q <= '0;
      end else if (accept && (len_q != '1)) begin
        len_q <= len_q + 1'b1;
      end
    end
  end

  assign busy      = !rst && (state_q != IDLE);
  assign frame_len = rst ? '0 : len_q;

endmodule
